// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the IF/ID payload type.
// Used by fetch_pc_unit and ifid_reg.
package fetch_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 16;

   localparam logic [PC_W-1:0]    RESET_VEC = PC_W'(32);
   localparam logic [PC_W-1:0]    ISR_VEC   = PC_W'(0);
   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               valid;
   } ifid_t;

   // Word-addressed increment; wraps naturally at 2^PC_W.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return pc + PC_W'(1);
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble (keeping the PC),
// hold freezes the contents, otherwise the fetched payload is captured.
module ifid_reg
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] FLUSH_INSTR = NOP_INSTR
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  hold,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q
);

   ifid_t q_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r <= '{instr: FLUSH_INSTR, pc: '0, valid: 1'b0};
      end else if (flush) begin
         q_r <= '{instr: FLUSH_INSTR, pc: d.pc, valid: 1'b0};
      end else if (!hold) begin
         q_r <= d;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC sequencer with IF/ID register, redirect, and optional
// interrupt entry / RTI return (enabled by defining PC_INT_EN).
module fetch_pc_unit #(
   parameter int unsigned                   PC_W      = fetch_pkg::PC_W,
   parameter int unsigned                   INSTR_W   = fetch_pkg::INSTR_W,
   parameter logic [fetch_pkg::PC_W-1:0]    RESET_VEC = fetch_pkg::RESET_VEC,
   parameter logic [fetch_pkg::PC_W-1:0]    ISR_VEC   = fetch_pkg::ISR_VEC,
   parameter logic [fetch_pkg::INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    pc_out,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               int_req,
   input  logic               rti_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic [PC_W-1:0]    epc,
   output logic               in_isr
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic            flush_c;
   logic            take_rti_c;
   logic            take_int_c;

   fetch_pkg::ifid_t ifid_d;
   fetch_pkg::ifid_t ifid_q;

`ifdef PC_INT_EN
   logic            int_pend_q;
   logic            in_isr_q;
   logic [PC_W-1:0] epc_q;

   // RTI only honoured inside an ISR; interrupt loses to every other event.
   always_comb begin
      take_rti_c = rti_valid & in_isr_q;
      take_int_c = int_pend_q & ~in_isr_q & ~stall & ~redirect_valid & ~take_rti_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_pend_q <= 1'b0;
         in_isr_q   <= 1'b0;
         epc_q      <= '0;
      end else begin
         // Sticky request; a request arriving on the take edge re-arms it.
         int_pend_q <= (int_pend_q & ~take_int_c) | int_req;
         if (take_int_c) begin
            in_isr_q <= 1'b1;
            epc_q    <= pc_q;
         end else if (take_rti_c) begin
            in_isr_q <= 1'b0;
         end
      end
   end

   assign epc    = epc_q;
   assign in_isr = in_isr_q;
`else
   logic unused_int_c;

   assign take_rti_c   = 1'b0;
   assign take_int_c   = 1'b0;
   assign epc          = '0;
   assign in_isr       = 1'b0;
   assign unused_int_c = int_req ^ rti_valid;
`endif

   // Next-PC select in edge priority order.
   always_comb begin
      pc_d    = pc_q;
      flush_c = 1'b0;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         flush_c = 1'b1;
      end else if (take_rti_c) begin
         pc_d    = epc;
         flush_c = 1'b1;
      end else if (take_int_c) begin
         pc_d    = ISR_VEC;
         flush_c = 1'b1;
      end else if (!stall) begin
         pc_d    = fetch_pkg::pc_inc(pc_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VEC;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      ifid_d       = '0;
      ifid_d.instr = instr_in;
      ifid_d.pc    = pc_q;
      ifid_d.valid = 1'b1;
   end

   ifid_reg #(
      .FLUSH_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk   (clk),
      .rst   (rst),
      .hold  (stall),
      .flush (flush_c),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign pc_out     = pc_q;
   assign ifid_instr = ifid_q.instr;
   assign ifid_pc    = ifid_q.pc;
   assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; interrupt scenarios
// run when PC_INT_EN is defined, otherwise int_req/rti_valid must be inert.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_out;
   logic [15:0] instr_in;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        int_req;
   logic        rti_valid;
   logic [15:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic [31:0] epc;
   logic        in_isr;

   int checks = 0;
   int errors = 0;

   fetch_pc_unit dut (
      .clk            (clk),
      .rst            (rst),
      .pc_out         (pc_out),
      .instr_in       (instr_in),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .int_req        (int_req),
      .rti_valid      (rti_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc        (ifid_pc),
      .ifid_valid     (ifid_valid),
      .epc            (epc),
      .in_isr         (in_isr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem(input logic [31:0] a);
      return a[15:0] ^ 16'h5A3C;
   endfunction

   always_comb instr_in = mem(pc_out);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      stall = 0; redirect_valid = 0; redirect_pc = '0; int_req = 0; rti_valid = 0;
      rst = 1'b1;
      #12;
      checks++;
      if ({pc_out, ifid_instr, ifid_pc, ifid_valid, epc, in_isr} !==
          {32'd32, 16'h0000, 32'd0, 1'b0, 32'd0, 1'b0})
      begin
         errors++;
         $display("FAIL reset: pc=%h instr=%h ifid_pc=%h v=%b epc=%h isr=%b, want pc=20 rest zero",
                  pc_out, ifid_instr, ifid_pc, ifid_valid, epc, in_isr);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({pc_out, ifid_pc, ifid_valid, ifid_instr} !==
             {32'(33 + i), 32'(32 + i), 1'b1, mem(32'(32 + i))}) begin
            errors++;
            $display("FAIL seq[%0d]: pc=%h ifid_pc=%h v=%b instr=%h, want pc=%h ifid_pc=%h v=1 instr=%h",
                     i, pc_out, ifid_pc, ifid_valid, ifid_instr, 32'(33 + i), 32'(32 + i),
                     mem(32'(32 + i)));
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      step();
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({pc_out, ifid_pc, ifid_valid, ifid_instr} !== {32'd34, 32'd33, 1'b1, mem(32'd33)}) begin
            errors++;
            $display("FAIL stall[%0d]: pc=%h ifid_pc=%h v=%b instr=%h, want pc=22 ifid_pc=21 v=1",
                     i, pc_out, ifid_pc, ifid_valid, ifid_instr);
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if ({pc_out, ifid_pc, ifid_valid, ifid_instr} !== {32'd35, 32'd34, 1'b1, mem(32'd34)}) begin
         errors++;
         $display("FAIL stall_release: pc=%h ifid_pc=%h v=%b, want pc=23 ifid_pc=22 v=1",
                  pc_out, ifid_pc, ifid_valid);
      end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      stall = 1'b0; redirect_valid = 1'b0;
      checks++;
      if ({pc_out, ifid_pc, ifid_valid, ifid_instr} !== {32'h100, 32'd35, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL redirect: pc=%h ifid_pc=%h v=%b instr=%h, want pc=100 ifid_pc=23 v=0 instr=0000",
                  pc_out, ifid_pc, ifid_valid, ifid_instr);
      end
      step();
      checks++;
      if ({pc_out, ifid_pc, ifid_valid, ifid_instr} !== {32'h101, 32'h100, 1'b1, mem(32'h100)}) begin
         errors++;
         $display("FAIL redirect_next: pc=%h ifid_pc=%h v=%b, want pc=101 ifid_pc=100 v=1",
                  pc_out, ifid_pc, ifid_valid);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (pc_out !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_load: pc=%h want ffffffff", pc_out);
      end
      step();
      checks++;
      if ({pc_out, ifid_pc, ifid_valid, ifid_instr} !==
          {32'h0, 32'hFFFF_FFFF, 1'b1, mem(32'hFFFF_FFFF)}) begin
         errors++;
         $display("FAIL wrap: pc=%h ifid_pc=%h v=%b, want pc=0 ifid_pc=ffffffff v=1",
                  pc_out, ifid_pc, ifid_valid);
      end
   endtask

`ifdef PC_INT_EN
   task automatic test_interrupt();
      redirect_valid = 1'b1; redirect_pc = 32'd40;
      step();
      redirect_valid = 1'b0;
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      checks++;
      if ({pc_out, in_isr} !== {32'd41, 1'b0}) begin
         errors++;
         $display("FAIL int_latch: pc=%h isr=%b, want pc=29 isr=0", pc_out, in_isr);
      end
      step();
      checks++;
      if ({pc_out, epc, in_isr, ifid_valid, ifid_pc} !== {32'd0, 32'd41, 1'b1, 1'b0, 32'd41}) begin
         errors++;
         $display("FAIL int_take: pc=%h epc=%h isr=%b v=%b ifid_pc=%h, want pc=0 epc=29 isr=1 v=0 ifid_pc=29",
                  pc_out, epc, in_isr, ifid_valid, ifid_pc);
      end
      step();
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      step();
      checks++;
      if ({pc_out, in_isr, epc, ifid_pc, ifid_valid} !== {32'd3, 1'b1, 32'd41, 32'd2, 1'b1}) begin
         errors++;
         $display("FAIL int_nested_held: pc=%h isr=%b epc=%h ifid_pc=%h, want pc=3 isr=1 epc=29 ifid_pc=2",
                  pc_out, in_isr, epc, ifid_pc);
      end
      rti_valid = 1'b1;
      step();
      rti_valid = 1'b0;
      checks++;
      if ({pc_out, in_isr, ifid_valid} !== {32'd41, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rti: pc=%h isr=%b v=%b, want pc=29 isr=0 v=0", pc_out, in_isr, ifid_valid);
      end
      step();
      checks++;
      if ({pc_out, epc, in_isr} !== {32'd0, 32'd41, 1'b1}) begin
         errors++;
         $display("FAIL int_after_rti: pc=%h epc=%h isr=%b, want pc=0 epc=29 isr=1", pc_out, epc, in_isr);
      end
      rti_valid = 1'b1;
      step();
      rti_valid = 1'b0;
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();
      redirect_valid = 1'b0;
      checks++;
      if ({pc_out, in_isr} !== {32'h200, 1'b0}) begin
         errors++;
         $display("FAIL redirect_beats_int: pc=%h isr=%b, want pc=200 isr=0", pc_out, in_isr);
      end
      step();
      checks++;
      if ({pc_out, epc, in_isr} !== {32'd0, 32'h200, 1'b1}) begin
         errors++;
         $display("FAIL int_after_redirect: pc=%h epc=%h isr=%b, want pc=0 epc=200 isr=1",
                  pc_out, epc, in_isr);
      end
   endtask
`else
   task automatic test_interrupt();
      redirect_valid = 1'b1; redirect_pc = 32'd40;
      step();
      redirect_valid = 1'b0;
      int_req = 1'b1;
      step();
      int_req = 1'b0;
      step();
      checks++;
      if ({pc_out, epc, in_isr, ifid_pc, ifid_valid} !== {32'd42, 32'd0, 1'b0, 32'd41, 1'b1}) begin
         errors++;
         $display("FAIL int_disabled: pc=%h epc=%h isr=%b ifid_pc=%h v=%b, want pc=2a epc=0 isr=0 ifid_pc=29 v=1",
                  pc_out, epc, in_isr, ifid_pc, ifid_valid);
      end
      rti_valid = 1'b1;
      step();
      rti_valid = 1'b0;
      checks++;
      if ({pc_out, in_isr, ifid_valid} !== {32'd43, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rti_disabled: pc=%h isr=%b v=%b, want pc=2b isr=0 v=1", pc_out, in_isr, ifid_valid);
      end
   endtask
`endif

   task automatic test_async_reset();
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({pc_out, ifid_instr, ifid_pc, ifid_valid, epc, in_isr} !==
          {32'd32, 16'h0000, 32'd0, 1'b0, 32'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: pc=%h instr=%h ifid_pc=%h v=%b epc=%h isr=%b, want reset values",
                  pc_out, ifid_instr, ifid_pc, ifid_valid, epc, in_isr);
      end
      #3;
      rst = 1'b0;
      step();
      step();
      checks++;
      if ({pc_out, in_isr, ifid_pc, ifid_valid} !== {32'd34, 1'b0, 32'd33, 1'b1}) begin
         errors++;
         $display("FAIL post_reset_seq: pc=%h isr=%b ifid_pc=%h v=%b, want pc=22 isr=0 ifid_pc=21 v=1",
                  pc_out, in_isr, ifid_pc, ifid_valid);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_stall();
      test_wrap();
      test_interrupt();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter sequencer and IF/ID pipeline register for the fetch stage. Drives the word address into the combinational instruction memory every cycle, captures the returned 16-bit instruction with its PC into the IF/ID register, and handles stall, redirect (branch/jump/RET), interrupt entry and RTI return. It sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
Parameters:
- PC_W, 32, PC / address width
- INSTR_W, 16, instruction width
- RESET_VEC, 32, PC loaded on reset (program region start)
- ISR_VEC, 0, PC loaded on interrupt entry
- NOP_INSTR, 16'h0000, instruction word injected on flush

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1, rising-edge clock
- rst, in, 1, asynchronous active-high reset
- pc_out, out, PC_W, current fetch address to instruction memory
- instr_in, in, INSTR_W, instruction returned for pc_out (same cycle)
- stall, in, 1, hold PC and IF/ID contents
- redirect_valid, in, 1, load redirect_pc next cycle, flush IF/ID
- redirect_pc, in, PC_W, redirect target
- int_req, in, 1, interrupt request (level or pulse; latched)
- rti_valid, in, 1, return from interrupt: PC ← epc, flush IF/ID
- ifid_instr, out, INSTR_W, registered instruction to decode
- ifid_pc, out, PC_W, PC of ifid_instr
- ifid_valid, out, 1, ifid_instr is a real fetched instruction
- epc, out, PC_W, saved return address
- in_isr, out, 1, interrupt service in progress

## Operation
- Per-edge priority: rst > redirect_valid > rti_valid > interrupt take > stall > sequential.
- Sequential: pc ← pc+1 (word addressing, modulo 2^PC_W; 0xFFFFFFFF wraps to 0); IF/ID ← {instr_in, pc_out, valid=1}.
- Stall: pc, ifid_* held unchanged; pending interrupt not taken.
- Redirect: pc ← redirect_pc; IF/ID ← {NOP_INSTR, pc_out, valid=0}. Ignores stall.
- RTI: pc ← epc; in_isr ← 0; IF/ID flushed. Ignored when in_isr=0.
- Interrupt: int_req sets int_pend (sticky). Taken when int_pend=1, in_isr=0, stall=0, no redirect/RTI: epc ← pc_out (address being fetched, squashed), pc ← ISR_VEC, in_isr ← 1, int_pend ← 0, IF/ID flushed. int_req during in_isr stays pending until after RTI.
- Redirect and pending interrupt in the same cycle: redirect taken; interrupt taken next unstalled cycle, so epc = redirect target.

## Timing
- Reset values: pc_out=RESET_VEC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0, epc=0, in_isr=0, int_pend=0.
- pc_out is a register output; instr_in is sampled at the edge ending the cycle in which pc_out was presented; fetch-to-IF/ID latency is 1 cycle.
- Redirect/RTI/interrupt: new PC appears on pc_out 1 cycle after the asserting edge; first valid instruction from the new stream on ifid_* 2 edges after.
- int_req asserted at edge N with no blockers: pc_out=ISR_VEC after edge N+1 (latch at N, take at N+1).
- rst asserted mid-operation clears all state immediately (asynchronously), regardless of stall or pending events.

## Configuration
- PC_INT_EN defined: interrupt/RTI logic as above.
- PC_INT_EN undefined: int_req and rti_valid ignored; epc tied 0, in_isr tied 0; no int_pend/epc flops.

## Structure
- Shared package fetch_pkg: PC_W, INSTR_W, RESET_VEC, ISR_VEC, NOP_INSTR constants, plus a packed ifid_t struct {instr, pc, valid}.
- One sub-module: ifid_reg (IF/ID register with stall-hold and flush-to-NOP); PC next-state logic and interrupt logic stay in fetch_pc_unit.

## Test plan
- Reset then 4 free-running cycles: pc_out 32→33→34→35→36; ifid_pc follows 1 cycle behind with valid=1 and instr matching memory.
- stall high 3 cycles at pc_out=34: pc_out and ifid_* frozen; resumes at 35 after release.
- redirect_valid with redirect_pc=0x100 while stall=1: next pc_out=0x100, ifid_valid=0, ifid_instr=16'h0000.
- int_req pulse at pc_out=40: epc=41 (fetch address at take edge), pc_out=0, in_isr=1; second int_req during ISR held; rti_valid → pc_out=41, then pending interrupt taken.
- pc forced to 0xFFFFFFFF via redirect: next sequential pc_out=0x00000000.
- rst asserted between clock edges mid-ISR: all outputs return to reset values immediately; PC_INT_EN undefined build: int_req has no effect.
